// File: rtl/lcd_pkg.sv
// Definitions shared by the HD44780 read engine and the write controller:
// FSM states, register-select/busy-flag constants and the default bus timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    ELOW,
    RESP
  } lcd_state_e;

  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;
  localparam int   LCD_BF_BIT   = 7;

  localparam int LCD_T_AS     = 1;
  localparam int LCD_T_EH     = 2;
  localparam int LCD_T_EL     = 2;
  localparam int LCD_POLL_MAX = 255;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for LCD bus phases: load T-1 on phase entry and
// done is high on the last cycle of that phase.
module lcd_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit bus read engine: BF/AC or data reads with optional busy polling.
// Build option LCD_POLL_TIMEOUT_EN bounds busy polling to POLL_MAX reads.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_EH     = LCD_T_EH,
  parameter int T_EL     = LCD_T_EL,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       bus_active,
  input  logic [7:0] db_in,
  output logic       rs,
  output logic       rw,
  output logic       e
);

  localparam int TW = $clog2(lcd_max3(T_AS, T_EH, T_EL)) + 1;

  if (T_AS < 1) begin : g_bad_t_as
    $error("T_AS must be >= 1");
  end
  if (T_EH < 1) begin : g_bad_t_eh
    $error("T_EH must be >= 1");
  end
  if (T_EL < 1) begin : g_bad_t_el
    $error("T_EL must be >= 1");
  end
  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("POLL_MAX must be >= 1");
  end

  lcd_state_e    state;
  logic          poll_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          busy_again;

  lcd_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Each phase reloads the timer on the cycle it is entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: begin
        tmr_load = req_valid;
        tmr_val  = TW'(T_AS - 1);
      end
      SETUP: begin
        tmr_load = tmr_done;
        tmr_val  = TW'(T_EH - 1);
      end
      EHIGH: begin
        tmr_load = tmr_done;
        tmr_val  = TW'(T_EL - 1);
      end
      ELOW: begin
        tmr_load = tmr_done;
        tmr_val  = TW'(T_AS - 1);
      end
      default: ;
    endcase
  end

`ifdef LCD_POLL_TIMEOUT_EN
  localparam int PCW = ($clog2(POLL_MAX + 1) > 8) ? $clog2(POLL_MAX + 1) : 8;

  logic [PCW-1:0] poll_cnt;
  logic           poll_limit;
  logic           rsp_timeout_q;

  assign poll_limit = (poll_cnt >= PCW'(POLL_MAX));
  assign busy_again = poll_q && rsp_data[LCD_BF_BIT] && !poll_limit;

  // poll_cnt holds the number of reads already sampled for this request.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_timeout_q <= (state == ELOW) && tmr_done && poll_q &&
                       rsp_data[LCD_BF_BIT] && poll_limit;
      if (state == IDLE && req_valid) begin
        poll_cnt <= '0;
      end else if (state == EHIGH && tmr_done) begin
        poll_cnt <= poll_cnt + PCW'(1);
      end
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign busy_again  = poll_q && rsp_data[LCD_BF_BIT];
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rs         <= LCD_RS_INSTR;
      rw         <= 1'b0;
      e          <= 1'b0;
      bus_active <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      poll_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            rs         <= req_rs;
            poll_q     <= req_poll && (req_rs != LCD_RS_DATA);
            rw         <= 1'b1;
            bus_active <= 1'b1;
            req_ready  <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (tmr_done) begin
            e     <= 1'b1;
            state <= EHIGH;
          end
        end
        EHIGH: begin
          if (tmr_done) begin
            e        <= 1'b0;
            rsp_data <= db_in;
            state    <= ELOW;
          end
        end
        ELOW: begin
          if (tmr_done) begin
            if (busy_again) begin
              state <= SETUP;
            end else begin
              rsp_valid  <= 1'b1;
              rw         <= 1'b0;
              bus_active <= 1'b0;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomized self-checking bench for lcd_bus_reader against a read-count model.
module tb_lcd_bus_reader;

  localparam int TAS  = 1;
  localparam int TEH  = 2;
  localparam int TEL  = 2;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       bus_active;
  logic [7:0] db_in = 8'h00;
  logic       rs;
  logic       rw;
  logic       e;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pv [16];

  lcd_bus_reader #(.T_AS(TAS), .T_EH(TEH), .T_EL(TEL), .POLL_MAX(PMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs      (req_rs),
    .req_poll    (req_poll),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .bus_active  (bus_active),
    .db_in       (db_in),
    .rs          (rs),
    .rw          (rw),
    .e           (e)
  );

  always #5 clk = ~clk;

  // Reference: number of reads, final byte, latency and timeout from pv[].
  task automatic model(input logic r, input logic p, output int ereads,
                       output logic [7:0] edata, output int elat, output logic etmo);
    ereads = 1;
    etmo   = 1'b0;
    if (!r && p) begin
      while (ereads < 16 && pv[ereads-1][7]) ereads++;
`ifdef LCD_POLL_TIMEOUT_EN
      if (ereads > PMAX) begin
        ereads = PMAX;
        etmo   = 1'b1;
      end
`endif
    end
    edata = pv[ereads-1];
    elat  = 1 + ereads * (TAS + TEH + TEL);
  endtask

  // Runs one request starting at a negedge in IDLE; returns observations.
  task automatic do_read(input logic r, input logic p, output int lat, output int pulses,
                         output logic [7:0] data, output logic tmo, output int viol,
                         output int ehbad);
    int run;
    int idx;
    logic pe, prs, prw;
    lat = -1; pulses = 0; data = 8'h00; tmo = 1'b0; viol = 0; ehbad = 0; run = 0;
    if (req_ready !== 1'b1) viol++;
    req_valid = 1'b1; req_rs = r; req_poll = p;
    @(negedge clk);
    pe = 1'b0; prs = r; prw = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      req_valid = 1'($urandom); req_rs = 1'($urandom); req_poll = 1'($urandom);
      if (rsp_valid === 1'b1) begin
        lat = cyc; data = rsp_data; tmo = rsp_timeout;
        if (rw !== 1'b0 || bus_active !== 1'b0 || e !== 1'b0 || req_ready !== 1'b0 || rs !== r)
          viol++;
        req_valid = 1'b0;
        break;
      end
      if (req_ready !== 1'b0 || bus_active !== 1'b1 || rw !== 1'b1 || rs !== r) viol++;
      if (e === 1'b1 && !pe) begin
        pulses++; run = 0;
        idx = (pulses > 16) ? 15 : pulses - 1;
        db_in = pv[idx];
      end
      if (e !== 1'b1 && pe && run != TEH) ehbad++;
      if (e === 1'b1) run++;
      if (e === 1'b1 && pe && (rs !== prs || rw !== prw)) viol++;
      if (e === 1'b1 && rw !== 1'b1) viol++;
      if (e !== 1'b1) db_in = 8'($urandom);
      pe = e; prs = rs; prw = rw;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || e !== 1'b0) viol++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", rs); end
    n_checks++; if (rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", rw); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL reset_e: got %b expected 0", e); end
    n_checks++; if (bus_active !== 1'b0) begin n_fail++; $display("FAIL reset_bus_active: got %b expected 0", bus_active); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 00", rsp_data); end
    n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_timeout: got %b expected 0", rsp_timeout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_read();
    int lat, pulses, viol, ehbad;
    logic [7:0] data;
    logic tmo;
    for (int i = 0; i < 16; i++) pv[i] = 8'h41;
    do_read(1'b1, 1'b0, lat, pulses, data, tmo, viol, ehbad);
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL data_latency: got %0d expected 6", lat); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL data_pulses: got %0d expected 1", pulses); end
    n_checks++; if (data !== 8'h41) begin n_fail++; $display("FAIL data_value: got %h expected 41", data); end
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL data_timeout: got %b expected 0", tmo); end
    n_checks++; if (ehbad != 0) begin n_fail++; $display("FAIL data_e_width: got %0d bad pulses expected 0", ehbad); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL data_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_bf_read();
    int lat, pulses, viol, ehbad;
    logic [7:0] data;
    logic tmo;
    for (int i = 0; i < 16; i++) pv[i] = 8'hA5;
    do_read(1'b0, 1'b0, lat, pulses, data, tmo, viol, ehbad);
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bf_pulses: got %0d expected 1", pulses); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL bf_value: got %h expected a5", data); end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL bf_latency: got %0d expected 6", lat); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL bf_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_poll();
    int lat, pulses, viol, ehbad, ereads, elat;
    logic [7:0] data, edata;
    logic tmo, etmo;
    for (int i = 0; i < 16; i++) pv[i] = (i < 3) ? 8'h80 : 8'h12;
    model(1'b0, 1'b1, ereads, edata, elat, etmo);
    do_read(1'b0, 1'b1, lat, pulses, data, tmo, viol, ehbad);
    n_checks++; if (pulses != ereads) begin n_fail++; $display("FAIL poll_pulses: got %0d expected %0d", pulses, ereads); end
    n_checks++; if (data !== edata) begin n_fail++; $display("FAIL poll_value: got %h expected %h", data, edata); end
    n_checks++; if (lat != elat) begin n_fail++; $display("FAIL poll_latency: got %0d expected %0d", lat, elat); end
    n_checks++; if (tmo !== etmo) begin n_fail++; $display("FAIL poll_timeout: got %b expected %b", tmo, etmo); end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL poll_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, viol, ehbad, ereads, elat, nb;
    logic [7:0] data, edata;
    logic tmo, etmo, r, p;
    for (int t = 0; t < 24; t++) begin
      r  = 1'($urandom);
      p  = 1'($urandom);
      nb = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++)
        pv[i] = (i < nb) ? (8'h80 | 8'($urandom)) : (8'h7F & 8'($urandom));
      model(r, p, ereads, edata, elat, etmo);
      do_read(r, p, lat, pulses, data, tmo, viol, ehbad);
      n_checks++;
      if (lat != elat || pulses != ereads || data !== edata || tmo !== etmo) begin
        n_fail++;
        $display("FAIL rand_%0d: got lat=%0d pulses=%0d data=%h tmo=%b expected lat=%0d pulses=%0d data=%h tmo=%b",
                 t, lat, pulses, data, tmo, elat, ereads, edata, etmo);
      end
      n_checks++;
      if (viol != 0 || ehbad != 0) begin
        n_fail++;
        $display("FAIL rand_protocol_%0d: got %0d violations %0d bad e widths expected 0", t, viol, ehbad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen, rsp_cnt, lat, pulses, viol, ehbad;
    logic [7:0] data;
    logic tmo;
    for (int i = 0; i < 16; i++) pv[i] = 8'h3C;
    req_valid = 1'b1; req_rs = 1'b1; req_poll = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (e === 1'b1) seen = 1;
      else @(negedge clk);
    end
    n_checks++; if (seen != 1) begin n_fail++; $display("FAIL rstmid_e_seen: got %0d expected 1", seen); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (e !== 1'b0 || rw !== 1'b0 || bus_active !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got e=%b rw=%b bus_active=%b req_ready=%b expected 0 0 0 1",
               e, rw, bus_active, req_ready);
    end
    rsp_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid === 1'b1) rsp_cnt++;
      @(negedge clk);
    end
    n_checks++; if (rsp_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", rsp_cnt); end
    do_read(1'b1, 1'b0, lat, pulses, data, tmo, viol, ehbad);
    n_checks++;
    if (lat != 6 || data !== 8'h3C || viol != 0) begin
      n_fail++;
      $display("FAIL rstmid_recover: got lat=%0d data=%h viol=%0d expected 6 3c 0", lat, data, viol);
    end
  endtask

`ifdef LCD_POLL_TIMEOUT_EN
  task automatic test_timeout();
    int lat, pulses, viol, ehbad;
    logic [7:0] data;
    logic tmo;
    for (int i = 0; i < 16; i++) pv[i] = 8'hFF;
    do_read(1'b0, 1'b1, lat, pulses, data, tmo, viol, ehbad);
    n_checks++; if (pulses != PMAX) begin n_fail++; $display("FAIL tmo_pulses: got %0d expected %0d", pulses, PMAX); end
    n_checks++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", tmo); end
    n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL tmo_value: got %h expected ff", data); end
    n_checks++;
    if (lat != 1 + PMAX * (TAS + TEH + TEL)) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d expected %0d", lat, 1 + PMAX * (TAS + TEH + TEL));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_data_read();
    test_bf_read();
    test_poll();
    test_back_to_back();
    test_reset_mid();
`ifdef LCD_POLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style 16x2 character LCD 8-bit parallel bus. The existing path only writes to the panel; this block does the reverse.
- It runs RW=1 read cycles to fetch either the busy flag/address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- It can optionally poll the busy flag until it clears.
- It sits beside the LCD write controller on the divided LCD clock. The top level uses bus_active to mux rs/e and to tristate db.

Parameters:
- T_AS, 1: cycles with RS/RW stable and E low before E rises (address setup); must be >=1.
- T_EH, 2: cycles with E high; db sampled on the last cycle; must be >=1.
- T_EL, 2: cycles with E low after the fall, before the next cycle or the response; must be >=1.
- POLL_MAX, 255: busy-poll read limit, used only with LCD_POLL_TIMEOUT_EN; must be >=1.

Ports:
- clk, input, 1: LCD-domain clock (divided system clock).
- rst, input, 1: synchronous active-high reset.
- req_valid, input, 1: request a read.
- req_ready, output, 1: high only in IDLE; a request is accepted when req_valid && req_ready.
- req_rs, input, 1: 0 = busy flag/AC read, 1 = data read.
- req_poll, input, 1: valid only with req_rs=0; repeat reads until BF (db[7]) = 0.
- rsp_valid, output, 1: one-cycle pulse; response data is valid in that cycle.
- rsp_data, output, 8: last byte sampled from db_in.
- rsp_timeout, output, 1: poll limit hit; qualified by rsp_valid; tied 0 without the feature.
- bus_active, output, 1: high from accept through the end of the last T_EL; the top level releases db drivers while high.
- db_in, input, 8: LCD data bus input from the pad.
- rs, output, 1: register select.
- rw, output, 1: 1 = read; 0 when idle.
- e, output, 1: enable strobe.

Behaviour:
- Reset values: rs=0, rw=0, e=0, bus_active=0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_timeout=0, state=IDLE, counters=0.
- All outputs are registered.
- States: IDLE -> SETUP -> EHIGH -> ELOW -> (SETUP | RESP) -> IDLE.
- IDLE:
  - req_ready=1.
  - On accept: latch rs_q <= req_rs and poll_q <= req_poll & ~req_rs (poll is ignored when req_rs=1).
  - Next cycle: rs=rs_q, rw=1, bus_active=1, e=0; enter SETUP.
- SETUP: e=0 for exactly T_AS cycles, then EHIGH.
- EHIGH:
  - e=1 for exactly T_EH cycles.
  - On the final EHIGH cycle, rsp_data <= db_in; the sampled value is retained.
- ELOW: e=0 for exactly T_EL cycles, with rw=1 and rs held. Then:
  - If poll_q=1 and sampled bit7=1, return to SETUP with no IDLE cycle.
  - Otherwise go to RESP.
- RESP:
  - One cycle: rsp_valid=1, rw=0, bus_active=0, rs holds its value.
  - Next state is IDLE.
- No response backpressure: the consumer must take rsp_valid when it pulses.
- Latency:
  - Single read: accept to rsp_valid = 1 + T_AS + T_EH + T_EL cycles (6 with defaults).
  - Poll: adds T_AS+T_EH+T_EL per extra read.
- Phase counter width: $clog2(max(T_AS,T_EH,T_EL))+1. It reloads at each phase entry.
- A req_valid that arrives while busy is not accepted and is not queued.
- Reset mid-operation: next edge forces e=0, rw=0, bus_active=0, IDLE. No rsp_valid is emitted and the partial read is dropped.
- e never rises while rw=0. rw never changes while e=1.

Optional Feature:
- LCD_POLL_TIMEOUT_EN defined:
  - An 8+ bit poll counter counts reads within one poll request.
  - When the counter reaches POLL_MAX with BF still 1, go to RESP with rsp_timeout=1 and rsp_data=last sample.
  - The counter clears on accept.
- Not defined:
  - Polling is unbounded.
  - rsp_timeout is constant 0 and no counter logic exists.

Decomposition:
- Shared package lcd_pkg holds:
  - State enum (IDLE, SETUP, EHIGH, ELOW, RESP).
  - Constants LCD_RS_INSTR=0, LCD_RS_DATA=1, LCD_BF_BIT=7.
  - Default timing constants, shared with the write controller.
- One sub-module, lcd_phase_timer: loadable down-counter with a done flag. It is reused by the writer.

Test Plan:
- Data read: req_rs=1, db_in=8'h41 during EHIGH -> rs=1, rw=1; e high exactly 2 cycles; rsp_valid 6 cycles after accept; rsp_data=8'h41; rsp_timeout=0.
- BF/AC read without poll: req_rs=0, req_poll=0, db_in=8'hA5 -> single E pulse; rsp_data=8'hA5 even though BF=1.
- Poll:
  - Setup: req_rs=0, req_poll=1; db_in=8'h80 for the first 3 E pulses, then 8'h12.
  - Expect: exactly 4 E pulses with no IDLE gap and bus_active continuously high.
  - Expect: rsp_data=8'h12, latency 1+4*5 = 21 cycles.
- Protocol invariants across random requests:
  - rw=1 whenever e=1.
  - rs/rw stable while e=1.
  - req_ready=0 from the accept cycle through RESP.
  - Back-to-back requests: each accepted in IDLE.
- Reset mid-EHIGH: assert rst for 1 cycle -> next edge e=0, rw=0, bus_active=0; no rsp_valid ever. A new request then completes normally.
- LCD_POLL_TIMEOUT_EN with POLL_MAX=3, db_in stuck at 8'hFF -> exactly 3 E pulses, then rsp_valid with rsp_timeout=1 and rsp_data=8'hFF.
